adder_share_arb: RTL and testbench

- Shares one pipelined WIDTH-bit adder between two requesters (port 0, port 1).
- Uses round-robin arbitration and a valid/ready request handshake.
- A requester tag travels down the pipeline with each operand set, so each result returns only to its issuer.
- Sits between client FSMs and the adder datapath; it is the only block that drives the adder inputs.

---
 rtl/adder_arb_pkg.sv | 34 +++
 rtl/pipe_add.sv | 58 +++++
 rtl/adder_share_arb.sv | 102 ++++++++++
 tb/tb_adder_share_arb.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the two-port shared-adder arbiter.
package adder_arb_pkg;

  // Number of requesters sharing the adder.
  localparam int NPORT = 2;

  // Operand width carried by a pipeline stage. Both adder_share_arb and
  // pipe_add take WIDTH from this value by default, and WIDTH must stay
  // equal to it, because stage_t carries the operands at this width.
  localparam int STAGE_W = 4;

  // One pipeline stage: operand set, issuing port and occupancy flag.
  typedef struct packed {
    logic [STAGE_W-1:0] a;
    logic [STAGE_W-1:0] b;
    logic               cin;
    logic               tag;
    logic               v;
  } stage_t;

  // Round-robin pointer update. After a grant, the other port gets
  // priority. With no grant, the pointer holds.
  function automatic logic rr_next(input logic ptr, input logic [NPORT-1:0] grant);
    logic nxt;
    nxt = ptr;
    if (grant[0]) begin
      nxt = 1'b1;
    end else if (grant[1]) begin
      nxt = 1'b0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pipe_add.sv
// LAT-stage registered adder. The tag and valid bits travel with the operands.
// The sum is formed after the last register. A hold register keeps the
// sum/cout outputs at their last valid value between results.
module pipe_add
  import adder_arb_pkg::*;
#(
  parameter int WIDTH = STAGE_W,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  stage_t           stage_i,
  output logic             rsp_v_o,
  output logic             rsp_tag_o,
  output logic [WIDTH-1:0] rsp_sum_o,
  output logic             rsp_cout_o
);

  stage_t           st_q [LAT];
  logic [WIDTH:0]   full_sum;
  logic [WIDTH:0]   hold_q;

  // Shift register. Stage 0 loads every cycle, so a cycle with no accept
  // inserts a bubble. Reset clears only the valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) begin
        st_q[k].v <= 1'b0;
      end
    end else begin
      st_q[0] <= stage_i;
      for (int k = 1; k < LAT; k++) begin
        st_q[k] <= st_q[k-1];
      end
    end
  end

  // Full-width sum of the last stage. Bit WIDTH is the carry-out.
  always_comb begin
    full_sum = {1'b0, st_q[LAT-1].a} + {1'b0, st_q[LAT-1].b}
             + {{WIDTH{1'b0}}, st_q[LAT-1].cin};
  end

  // Remember the most recent valid result so the outputs hold between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (st_q[LAT-1].v) begin
      hold_q <= full_sum;
    end
  end

  assign rsp_v_o    = st_q[LAT-1].v;
  assign rsp_tag_o  = st_q[LAT-1].tag;
  assign rsp_sum_o  = st_q[LAT-1].v ? full_sum[WIDTH-1:0] : hold_q[WIDTH-1:0];
  assign rsp_cout_o = st_q[LAT-1].v ? full_sum[WIDTH]     : hold_q[WIDTH];

endmodule

// File: rtl/adder_share_arb.sv
// Two-port round-robin front end for one shared pipelined adder.
// The issuing port travels with each operation, so each result is
// steered back only to the port that issued it.
module adder_share_arb
  import adder_arb_pkg::*;
#(
  parameter int WIDTH = STAGE_W,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic             req_cin0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic             req_cin1,
  output logic [1:0]       rsp_valid,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic [3:0]       inflight,
  output logic             idle
);

  logic       ptr_q, ptr_d;
  logic [3:0] inflight_q, inflight_d;
  logic [1:0] gnt;
  logic       accept;
  stage_t     stage_in;
  logic       pipe_v;
  logic       pipe_tag;

  // Grant: a lone requester wins. On contention, the pointer picks the port.
  always_comb begin
    gnt = 2'b00;
    case (req_valid)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  assign req_ready = gnt;
  assign accept    = |gnt;

  // Steer the granted port's operands into the pipeline entry.
  always_comb begin
    stage_in     = '0;
    stage_in.v   = accept;
    stage_in.tag = gnt[1];
    stage_in.a   = gnt[1] ? req_a1   : req_a0;
    stage_in.b   = gnt[1] ? req_b1   : req_b0;
    stage_in.cin = gnt[1] ? req_cin1 : req_cin0;
  end

  pipe_add #(
    .WIDTH (WIDTH),
    .LAT   (LAT)
  ) u_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .stage_i    (stage_in),
    .rsp_v_o    (pipe_v),
    .rsp_tag_o  (pipe_tag),
    .rsp_sum_o  (rsp_sum),
    .rsp_cout_o (rsp_cout)
  );

  // Next pointer and occupancy. An accept and an exit on the same edge cancel.
  always_comb begin
    ptr_d      = rr_next(ptr_q, gnt);
    inflight_d = inflight_q;
    if (accept && !pipe_v) begin
      inflight_d = inflight_q + 4'd1;
    end else if (!accept && pipe_v) begin
      inflight_d = inflight_q - 4'd1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= 1'b0;
      inflight_q <= 4'd0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
    end
  end

  // Response demux: strobe only the port named by the exiting tag.
  for (genvar gi = 0; gi < NPORT; gi++) begin : g_rsp
    assign rsp_valid[gi] = pipe_v && (pipe_tag == 1'(gi));
  end

  assign inflight = inflight_q;
  assign idle     = (inflight_q == 4'd0) && (req_valid == 2'b00);

endmodule

// File: tb/tb_adder_share_arb.sv
// Randomised and directed bench for adder_share_arb, compared against a
// transaction-level model (grant rule + queue of expected results).
module tb_adder_share_arb;

  localparam int W   = 4;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [W-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic         req_cin0 = 1'b0, req_cin1 = 1'b0;
  logic [1:0]   rsp_valid;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic [3:0]   inflight;
  logic         idle;

  adder_share_arb #(.WIDTH(W), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_cin0  (req_cin0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .req_cin1  (req_cin1),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .inflight  (inflight),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int tag;
    int sum;
    int cout;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   m_ptr = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model grant: lone requester wins, contention resolved by pointer.
  function automatic logic [1:0] model_grant(input logic [1:0] v);
    if (v == 2'b01) return 2'b01;
    if (v == 2'b10) return 2'b10;
    if (v == 2'b11) return (m_ptr == 0) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  // One clock cycle: drive, check against the model, then advance the model on the edge.
  task automatic do_cycle(input logic [1:0] v,
                          input logic [W-1:0] a0, input logic [W-1:0] b0, input logic c0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1, input logic c1);
    logic [1:0] g;
    logic [1:0] exp_rv;
    exp_t       e;
    int         s;
    @(negedge clk);
    req_valid = v;
    req_a0 = a0; req_b0 = b0; req_cin0 = c0;
    req_a1 = a1; req_b1 = b1; req_cin1 = c1;
    #1;
    g = model_grant(v);
    chk("req_ready", 32'(req_ready), 32'(g));
    chk("inflight", 32'(inflight), 32'(q.size()));
    chk("idle", 32'(idle), 32'((q.size() == 0) && (v == 2'b00)));
    exp_rv = 2'b00;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      exp_rv = (e.tag == 0) ? 2'b01 : 2'b10;
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
      chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
      $display("cyc %0d rsp port%0d sum=%0h cout=%0b", cyc, e.tag, rsp_sum, rsp_cout);
    end else begin
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    end
    @(posedge clk);
    cyc++;
    if (g != 2'b00) begin
      if (g[0]) s = int'(a0) + int'(b0) + int'(c0);
      else      s = int'(a1) + int'(b1) + int'(c1);
      q.push_back('{due: cyc + LAT - 1, tag: (g[1] ? 1 : 0), sum: s % (1 << W), cout: s / (1 << W)});
      m_ptr = g[0] ? 1 : 0;
    end
  endtask

  task automatic check_reset_outputs(input string where);
    chk({where, ".req_ready"}, 32'(req_ready), 32'd0);
    chk({where, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({where, ".rsp_sum"},   32'(rsp_sum),   32'd0);
    chk({where, ".rsp_cout"},  32'(rsp_cout),  32'd0);
    chk({where, ".inflight"},  32'(inflight),  32'd0);
    chk({where, ".idle"},      32'(idle),      32'd1);
  endtask

  // Short asynchronous reset pulse inside the low clock phase.
  task automatic reset_pulse();
    @(negedge clk);
    req_valid = 2'b00;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    $display("cyc %0d async reset pulse", cyc);
    #1 rst_n = 1'b1;
    q.delete();
    m_ptr = 0;
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    // Power-on reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check_reset_outputs("por");
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;

    // Single op on port 0: 0xC + 0xA = 0x16.
    do_cycle(2'b01, 4'hC, 4'hA, 1'b0, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) do_cycle(2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);

    // Contention: grants alternate and inflight reaches LAT.
    for (int i = 0; i < 4; i++) do_cycle(2'b11, 4'd1, 4'd1, 1'b0, 4'd2, 4'd2, 1'b0);
    for (int i = 0; i < 3; i++) do_cycle(2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);

    // Back-to-back port 1 stream: every k + (15-k) + 1 = 16.
    for (int k = 0; k < 16; k++) do_cycle(2'b10, 4'h0, 4'h0, 1'b0, 4'(k), 4'(15 - k), 1'b1);
    for (int i = 0; i < 3; i++) do_cycle(2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);

    // Port 1 blocked by port 0, then changes operands before its own grant.
    do_cycle(2'b11, 4'd3, 4'd4, 1'b0, 4'd1, 4'd1, 1'b0);
    do_cycle(2'b10, 4'd0, 4'd0, 1'b0, 4'd7, 4'd8, 1'b1);
    // Port 1 loses, then withdraws: no result must appear for it.
    do_cycle(2'b11, 4'd5, 4'd5, 1'b1, 4'd9, 4'd9, 1'b1);
    for (int i = 0; i < 3; i++) do_cycle(2'b00, 4'h0, 4'h0, 1'b0, 4'hF, 4'hF, 1'b1);

    // Reset with operations in flight; afterwards port 0 has priority again.
    do_cycle(2'b11, 4'd6, 4'd6, 1'b0, 4'd2, 4'd3, 1'b0);
    do_cycle(2'b11, 4'd6, 4'd6, 1'b0, 4'd2, 4'd3, 1'b0);
    reset_pulse();
    for (int i = 0; i < 3; i++) do_cycle(2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
    do_cycle(2'b11, 4'd1, 4'd2, 1'b1, 4'd4, 4'd4, 1'b1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      do_cycle(2'($urandom_range(0, 3)),
               4'($urandom), 4'($urandom), 1'($urandom),
               4'($urandom), 4'($urandom), 1'($urandom));
    end
    for (int i = 0; i < LAT + 2; i++) do_cycle(2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
